// File: rtl/jmb_dad_acc_pkg.sv
// Shared definitions for the jmb_dad frame accumulator: FSM encodings and default widths.
package jmb_dad_acc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/jmb_dad_sat_add.sv
// Combinational W-bit two's complement adder with signed-overflow flag.
// Optional clamping to the signed range when JMB_DAD_SAT_EN is defined.
module jmb_dad_sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  always_comb begin
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef JMB_DAD_SAT_EN
    // Both operands share a sign on overflow, so a's sign picks the rail.
    if (ovf) sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else     sum = raw;
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/jmb_dad_acc.sv
// Frame accumulator: sums frame_len signed samples per frame and presents the total.
// Build option JMB_DAD_SAT_EN selects saturating instead of wrapping accumulation.
module jmb_dad_acc
  import jmb_dad_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  frame_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);

  // Length 0 means 2^CNT_W, which is exactly the zero pattern with a carry bit on top.
  function automatic logic [CNT_W:0] eff_len(input logic [CNT_W-1:0] len);
    return {~|len, len};
  endfunction

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   in_sext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic [CNT_W:0]     cnt_inc;
  logic               accept;

  assign in_sext  = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign cnt_inc  = cnt_q + CNT_ONE;
  assign in_ready = (state_q != ST_HOLD) || out_ready;
  assign accept   = in_valid && in_ready;

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

  jmb_dad_sat_add #(.W(ACC_W)) u_add (
    .a   (acc_q),
    .b   (in_sext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        // A HOLD accept overlaps the output transfer with the next frame's first sample.
        if (accept) begin
          acc_d   = in_sext;
          cnt_d   = CNT_ONE;
          len_d   = frame_len;
          ovf_d   = 1'b0;
          state_d = (eff_len(frame_len) == CNT_ONE) ? ST_HOLD : ST_ACCUM;
        end else if (state_q == ST_HOLD && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (cnt_inc == eff_len(len_q)) state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_jmb_dad_acc.sv
// Directed scoreboard bench for jmb_dad_acc (default widths plus an ACC_W=17 instance).
module tb_jmb_dad_acc;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [7:0]  frame_len;
  logic        rdy_base, tog_en, tog_q;
  logic        out_ready;
  logic        in_ready, out_valid, out_ovf;
  logic [23:0] out_data;
  logic        in_ready17, out_valid17, out_ovf17;
  logic [16:0] out_data17;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [23:0] data;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) tog_q <= ~tog_q;
  assign out_ready = tog_en ? tog_q : rdy_base;

  jmb_dad_acc dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .frame_len(frame_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  jmb_dad_acc #(.ACC_W(17)) dut17 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready17),
    .in_data(in_data), .frame_len(frame_len), .out_valid(out_valid17),
    .out_ready(out_ready), .out_data(out_data17), .out_ovf(out_ovf17)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: any visible total must match the scoreboard head, held until taken.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
      else begin
        chk("out_data", 32'(out_data), 32'(sb[0].data));
        chk("out_ovf", 32'(out_ovf), 32'(sb[0].ovf));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] d);
    logic ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && n < 200) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    int c0;
    logic [16:0] exp17;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; frame_len = '0;
    rdy_base = 1'b1; tog_en = 1'b0; tog_q = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock) #1;

    // Reset in the middle of a frame discards the partial sum.
    frame_len = 8'd4;
    send(16'd1); send(16'd1); send(16'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock) #1;
    sb.push_back('{24'd10, 1'b0});
    send(16'd1); send(16'd2); send(16'd3); send(16'd4);
    chk("latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Mixed-sign frame.
    sb.push_back('{24'(15 + 17 - 6 + 8), 1'b0});
    send(16'h000F); send(16'h0011); send(16'hFFFA); send(16'h0008);
    drain();

    // One-sample frames against a toggling consumer.
    frame_len = 8'd1;
    tog_en = 1'b1;
    for (int i = 1; i <= 6; i++) sb.push_back('{24'(i * 3), 1'b0});
    for (int i = 1; i <= 6; i++) send(16'(i * 3));
    drain();
    tog_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Back-to-back frames with no bubble.
    frame_len = 8'd2;
    sb.push_back('{24'd10, 1'b0});
    sb.push_back('{24'd14, 1'b0});
    c0 = cyc;
    send(16'd5); send(16'd5); send(16'd7); send(16'd7);
    chk("b2b_cycles", 32'(cyc - c0), 32'd4);
    drain();

    // Overflow at ACC_W=17; the 24-bit instance holds the same sum without overflow.
    frame_len = 8'd3;
    sb.push_back('{24'h017FFD, 1'b0});
    send(16'h7FFF); send(16'h7FFF); send(16'h7FFF);
`ifdef JMB_DAD_SAT_EN
    exp17 = 17'h0FFFF;
`else
    exp17 = 17'h17FFD;
`endif
    chk("ovf17_valid", 32'(out_valid17), 32'd1);
    chk("ovf17_data", 32'(out_data17), 32'(exp17));
    chk("ovf17_flag", 32'(out_ovf17), 32'd1);
    drain();

    // Length 0 means 256; a mid-frame frame_len change is ignored.
    frame_len = 8'd0;
    sb.push_back('{24'd256, 1'b0});
    send(16'd1);
    frame_len = 8'd3;
    for (int i = 1; i < 255; i++) send(16'd1);
    chk("len0_not_yet", 32'(out_valid), 32'd0);
    send(16'd1);
    chk("len0_valid", 32'(out_valid), 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
